instruction_loader: RTL
=======================

Name: instruction_loader

Overview:
- Writer side of the instruction-memory interface. The CPU fetch path reads instruction memory and the decoder decodes it; this block fills that memory.
- It receives a byte stream through a valid/ready handshake, assembles INSTRUCTION_WIDTH-bit words (high byte first), and writes them to instruction memory starting at address 0.
- The CPU is held in reset until a load completes with a correct checksum. The block is used for boot and program reload without resynthesis.

Parameters:
- INSTRUCTION_WIDTH, 16: instruction word width. Fixed at 2 bytes; values other than 16 are unsupported.
- ADDRESS_WIDTH, 11: instruction memory address width. Capacity is 2^ADDRESS_WIDTH words.

Ports:
- clock_in  in  1  system clock; all state changes on its rising edge.
- reset_in  in  1  asynchronous, active-high reset.
- start_in  in  1  one-cycle pulse: begin, or restart, a load.
- byte_in  in  8  stream data byte.
- byte_valid_in  in  1  byte_in holds a valid byte.
- byte_ready_out  out  1  loader can accept a byte. A byte transfers only when byte_valid_in=1 and byte_ready_out=1 at a clock edge.
- imem_addr_out  out  ADDRESS_WIDTH  instruction memory write address.
- imem_data_out  out  INSTRUCTION_WIDTH  instruction memory write data.
- imem_wr_out  out  1  one-cycle write strobe.
- cpu_reset_out  out  1  drives the CPU acc/pc/status/ir reset chain; 1 = CPU held in reset.
- busy_out  out  1  load in progress.
- done_out  out  1  sticky; last load succeeded.
- error_out  out  1  sticky; last load failed.
- word_count_out  out  ADDRESS_WIDTH+1  word count N received in the header.

Behaviour:
- Reset (asynchronous, immediate):
  - State IDLE.
  - cpu_reset_out=1.
  - All other outputs 0; internal address, checksum and byte buffer cleared.
- Stream format, in order:
  - LEN_HI, LEN_LO: 16-bit word count N.
  - N words, each sent as high byte then low byte.
  - One checksum byte equal to the XOR of all word bytes. Length bytes are excluded from the checksum.
- All outputs are registered.
- States:
  - IDLE: ready=0. On start_in go to LEN_HI.
  - LEN_HI, LEN_LO: ready=1. Capture N. Exit LEN_LO as follows:
    - N==0 or N>2^ADDRESS_WIDTH: go to ERROR.
    - Otherwise: go to DATA_HI, with address=0 and checksum=0.
  - DATA_HI: ready=1. Latch the high byte, XOR it into the checksum, go to DATA_LO.
  - DATA_LO: ready=1. Latch the low byte, XOR it into the checksum, go to WRITE.
  - WRITE: ready=0. Drive imem_wr_out=1 for exactly one cycle, with imem_addr_out=current address and imem_data_out={hi,lo}. Next state:
    - Last word: go to CHECK.
    - Otherwise: increment address, go to DATA_HI.
  - CHECK: ready=1. On the accepted byte:
    - Byte equals checksum: go to DONE.
    - Otherwise: go to ERROR.
  - DONE: done_out=1, cpu_reset_out=0, ready=0.
  - ERROR: error_out=1, cpu_reset_out=1, ready=0.
  - DONE and ERROR are held until the next start_in.
- start_in in any state other than IDLE:
  - Go to LEN_HI.
  - Clear done_out and error_out; clear address and checksum; discard any partially assembled word.
  - cpu_reset_out=1 from the following cycle.
  - A byte offered in that same cycle is not accepted.
- busy_out=1 in LEN_HI through CHECK, else 0.
- Throughput and latency:
  - Each state holds until its byte is accepted; byte_valid_in=0 stalls with no timeout.
  - Minimum 3 cycles per word (2 handshakes + WRITE).
  - done_out=1 and cpu_reset_out=0 in the cycle after the checksum byte is accepted.
- Words written before a checksum failure stay in memory. The CPU still stays in reset.
- N=2^ADDRESS_WIDTH is legal. Address wrap never occurs because the last word ends the data phase.
- word_count_out is updated when LEN_LO is accepted and held until the next LEN_LO.

Test Plan:
1. Nominal load. After reset, pulse start_in, then stream 00 02 18 05 20 03 3E with byte_valid_in always 1.
   - Required: two writes, addr 0 data 0x1805 (LDI 5) and addr 1 data 0x2003 (ADD 3), each strobe exactly one cycle.
   - Required: done_out=1, cpu_reset_out=0, word_count_out=2.
2. Backpressure. Same stream as 1, with byte_valid_in low 3 cycles between each byte.
   - Required: identical writes and result.
   - Required: byte_ready_out=0 during each WRITE cycle, and no byte is lost or duplicated.
3. Bad checksum. Same stream as 1, with final byte 0x3F.
   - Required: both words are still written.
   - Required: error_out=1, done_out=0, cpu_reset_out stays 1.
4. Length errors.
   - Header 00 00: ERROR directly after LEN_LO, no writes.
   - Header 08 01 (N=2049, ADDRESS_WIDTH=11): ERROR, no writes.
   - Header 08 00 (N=2048): accepted; last write at address 0x7FF.
5. Restart. Pulse start_in after 3 data bytes of the stream in 1, then send the full stream of 1.
   - Required: first write is at addr 0 with data 0x1805; no stale byte is used; load succeeds.
6. Asynchronous reset. Assert reset_in between clock edges in the middle of the DATA_LO phase.
   - Required: cpu_reset_out=1 and all other outputs 0 immediately, without waiting for a clock edge.
   - Required: after release, the loader stays IDLE until start_in.

Source files
------------

// File: rtl/instruction_loader.sv
// Boot/reload loader: byte stream -> 16-bit instruction words in imem from address 0, CPU held in reset until checksum passes.
// Latency: write strobe one cycle after the low byte is accepted; done_out/cpu_reset_out release one cycle after the checksum byte.
// Backpressure: byte_ready_out drops during WRITE and outside a load; any state stalls indefinitely while byte_valid_in is low.
module instruction_loader #(
    parameter int INSTRUCTION_WIDTH = 16,
    parameter int ADDRESS_WIDTH     = 11
) (
    input  logic                         clock_in,
    input  logic                         reset_in,
    input  logic                         start_in,
    input  logic [7:0]                   byte_in,
    input  logic                         byte_valid_in,
    output logic                         byte_ready_out,
    output logic [ADDRESS_WIDTH-1:0]     imem_addr_out,
    output logic [INSTRUCTION_WIDTH-1:0] imem_data_out,
    output logic                         imem_wr_out,
    output logic                         cpu_reset_out,
    output logic                         busy_out,
    output logic                         done_out,
    output logic                         error_out,
    output logic [ADDRESS_WIDTH:0]       word_count_out
);

    typedef enum logic [3:0] {
        S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_WRITE, S_CHECK, S_DONE, S_ERROR
    } state_t;

    localparam logic [16:0] MAX_WORDS = 17'd1 << ADDRESS_WIDTH;

    state_t                   state, state_nxt;
    logic [7:0]               len_hi;
    logic [7:0]               hi_byte;
    logic [7:0]               checksum;
    logic [ADDRESS_WIDTH-1:0] addr;
    logic [ADDRESS_WIDTH-1:0] last_addr;
    logic [15:0]              len_word;
    logic                     len_bad;
    logic                     accept;
    logic                     last_word;

    // A byte offered alongside start_in is never consumed.
    assign accept    = byte_valid_in && byte_ready_out && !start_in;
    assign len_word  = {len_hi, byte_in};
    assign len_bad   = (len_word == 16'd0) || ({1'b0, len_word} > MAX_WORDS);
    assign last_word = (addr == last_addr);

    always_comb begin
        state_nxt = state;
        if (start_in) begin
            state_nxt = S_LEN_HI;
        end else begin
            case (state)
                S_LEN_HI:  if (accept) state_nxt = S_LEN_LO;
                S_LEN_LO:  if (accept) state_nxt = len_bad ? S_ERROR : S_DATA_HI;
                S_DATA_HI: if (accept) state_nxt = S_DATA_LO;
                S_DATA_LO: if (accept) state_nxt = S_WRITE;
                S_WRITE:   state_nxt = last_word ? S_CHECK : S_DATA_HI;
                S_CHECK:   if (accept) state_nxt = (byte_in == checksum) ? S_DONE : S_ERROR;
                default:   state_nxt = state;
            endcase
        end
    end

    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            len_hi         <= 8'd0;
            hi_byte        <= 8'd0;
            checksum       <= 8'd0;
            addr           <= '0;
            last_addr      <= '0;
            word_count_out <= '0;
            imem_addr_out  <= '0;
            imem_data_out  <= '0;
        end else if (start_in) begin
            hi_byte  <= 8'd0;
            checksum <= 8'd0;
            addr     <= '0;
        end else begin
            case (state)
                S_LEN_HI: if (accept) len_hi <= byte_in;
                S_LEN_LO: if (accept) begin
                    word_count_out <= len_word[ADDRESS_WIDTH:0];
                    // N = 2^ADDRESS_WIDTH wraps to all-ones, which is exactly the final address.
                    last_addr      <= len_word[ADDRESS_WIDTH-1:0] - ADDRESS_WIDTH'(1);
                    addr           <= '0;
                    checksum       <= 8'd0;
                end
                S_DATA_HI: if (accept) begin
                    hi_byte  <= byte_in;
                    checksum <= checksum ^ byte_in;
                end
                S_DATA_LO: if (accept) begin
                    checksum      <= checksum ^ byte_in;
                    imem_addr_out <= addr;
                    imem_data_out <= {hi_byte, byte_in};
                end
                S_WRITE: if (!last_word) addr <= addr + ADDRESS_WIDTH'(1);
                default: ;
            endcase
        end
    end

    // Status outputs are registered images of the state being entered.
    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            byte_ready_out <= 1'b0;
            busy_out       <= 1'b0;
            imem_wr_out    <= 1'b0;
            done_out       <= 1'b0;
            error_out      <= 1'b0;
            cpu_reset_out  <= 1'b1;
        end else begin
            byte_ready_out <= (state_nxt == S_LEN_HI)  || (state_nxt == S_LEN_LO) ||
                              (state_nxt == S_DATA_HI) || (state_nxt == S_DATA_LO) ||
                              (state_nxt == S_CHECK);
            busy_out       <= (state_nxt != S_IDLE) && (state_nxt != S_DONE) &&
                              (state_nxt != S_ERROR);
            imem_wr_out    <= (state_nxt == S_WRITE);
            done_out       <= (state_nxt == S_DONE);
            error_out      <= (state_nxt == S_ERROR);
            cpu_reset_out  <= (state_nxt != S_DONE);
        end
    end

endmodule
